fetch_unit: RTL and testbench
=============================

# fetch_unit

Fetch stage of the pipelined ARM core. It sits directly upstream of the controller and decode logic. It owns PCF and the single outstanding request to a variable-latency instruction memory, and delivers InstrD, PCPlus8D and ValidD through the IF/ID register. It handles branch redirects from Execute and PC writes from Writeback, discards stale memory responses after a redirect, and absorbs decode stalls in a one-entry skid buffer.

## Interface
- RESET_PC, 32'h00000000, PC value loaded by reset.
- BUBBLE, 32'hE1800000, bubble encoding placed in InstrD (ORR r0,r0,r0, AL, S=0).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  request to instruction memory this cycle.
- imem_addr  out  32  word address of the request; always equals PCF.
- imem_rvalid  in  1  response valid; arrives ≥1 cycle after the accepted request.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
- StallD  in  1  hold the IF/ID register.
- FlushD  in  1  load BUBBLE into IF/ID; wins over StallD.
- PCWrPendingF  in  1  a PC write is in flight; no new request may issue.
- BranchTakenE  in  1  redirect to ALUResultE.
- ALUResultE  in  32  branch target.
- PCSrcW  in  1  redirect to ResultW.
- ResultW  in  32  PC write target.
- PCF  out  32  current fetch PC.
- InstrD  out  32  decode-stage instruction.
- PCPlus8D  out  32  PC of InstrD plus 8, used as the R15 read value.
- ValidD  out  1  InstrD holds a real fetched instruction.

## Operation
- The FSM has four states: REQ, WAIT, FULL and DRAIN.
- **REQ**
  - Sets imem_req=1 when PCWrPendingF=0 and no redirect occurs this cycle, then moves to WAIT.
  - Otherwise it stays in REQ with imem_req=0.
- **WAIT** (one request outstanding)
  - On imem_rvalid with StallD=0 and FlushD=0: loads IF/ID with {imem_rdata, PCF+8, valid=1}, sets PCF←PCF+4, moves to REQ.
  - On imem_rvalid with StallD=1: captures {imem_rdata, PCF+8} in the skid register, sets PCF←PCF+4, moves to FULL.
  - On imem_rvalid with FlushD=1 and StallD=0: the word is dropped, PCF is unchanged, moves to REQ. The hazard unit asserts FlushD only alongside a redirect.
- **FULL**
  - When StallD=0, moves the skid contents into IF/ID and goes to REQ.
  - imem_req=0 while in FULL.
- **DRAIN**
  - Waits for the stale response, discards it (IF/ID untouched), then moves to REQ.
  - imem_req=0 while in DRAIN.
- **Redirect target:** BranchTakenE has priority over PCSrcW; target = BranchTakenE ? ALUResultE : ResultW.
- **On redirect:** PCF←target and the skid buffer is invalidated.
  - State becomes DRAIN if a request is outstanding with no imem_rvalid this cycle. This covers WAIT, and REQ issuing this cycle, but REQ is blocked from issuing on redirect.
  - Otherwise state becomes REQ, and any imem_rvalid arriving in that same cycle is discarded.
- **Redirect in DRAIN:** PCF is updated and the state stays DRAIN.
- **Redirect in DRAIN coinciding with imem_rvalid:** the response is discarded, PCF is updated, state goes to REQ.
- **IF/ID register precedence:** FlushD > StallD > load. Flush loads {BUBBLE, 0, 0}.
- **Arithmetic:** 32-bit modular, wraps silently (32'hFFFFFFFC+4 = 0).

## Timing
- **Reset values:**
  - PCF=RESET_PC, state=REQ, skid invalid.
  - InstrD=BUBBLE, PCPlus8D=0, ValidD=0.
  - imem_req=0 during the reset cycle.
- **Reset mid-operation:** an outstanding response arriving after reset is ignored. State REQ issues only in the first cycle with reset=0.
- **Best-case throughput:** one instruction every 2 cycles with 1-cycle memory latency (REQ→WAIT→REQ).
- **Request-to-InstrD latency:** memory latency + 1 edge.
- imem_req and imem_addr are functions of registered state and current inputs only; there is no combinational path from imem_rvalid to imem_req.
- **Ordering:** at most one outstanding request, and responses are never reordered.

## Test plan
- **Reset then straight-line fetch:** reset 2 cycles with 1-cycle latency memory → requests at 0x0, 0x4, 0x8 in alternate cycles; InstrD follows with ValidD=1 and PCPlus8D=0x8, 0xC, 0x10.
- **Decode stall:** StallD high for 3 cycles while a response returns → FULL entered; InstrD held; no request issued; the skid word appears 1 cycle after StallD drops; PCF advanced by exactly 4.
- **Branch during outstanding 3-cycle-latency request:** BranchTakenE=1 with ALUResultE=0x100 → DRAIN; the stale word never reaches InstrD; next imem_addr=0x100.
- **Simultaneous redirects:** BranchTakenE=1 (0x200) and PCSrcW=1 (0x300) in the same cycle → PCF=0x200.
- **PCWrPendingF held 3 cycles in REQ:** imem_req stays 0 → PCSrcW=1 with ResultW=0x40 → next request at 0x40.
- **FlushD and StallD together:** InstrD=BUBBLE and ValidD=0. Separately, PCF=0xFFFFFFFC fetch → PCF wraps to 0x0 and PCPlus8D=0x4.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Fetch stage of the pipelined ARM core. Owns the fetch PC (PCF) and the single
// outstanding request to a variable-latency instruction memory, and drives the
// IF/ID register (InstrD, PCPlus8D, ValidD) consumed by decode.
//
// Redirects come from Execute (BranchTakenE/ALUResultE, higher priority) and
// Writeback (PCSrcW/ResultW). A response belonging to a request issued before
// a redirect is drained and discarded. A response that returns while decode is
// stalled is parked in a one-entry skid register until the stall releases.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req, imem_addr        request strobe and word address (== PCF)
//   imem_rvalid, imem_rdata    memory response
//   StallD, FlushD             IF/ID hold / bubble (flush wins)
//   PCWrPendingF               PC write in flight, blocks new requests
//   BranchTakenE, ALUResultE   Execute redirect
//   PCSrcW, ResultW            Writeback redirect
//   PCF                        current fetch PC
//   InstrD, PCPlus8D, ValidD   IF/ID register contents
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'hE180_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCWrPendingF,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    // REQ: may issue; WAIT: live request outstanding; FULL: skid holds a word;
    // DRAIN: outstanding request is stale and its response must be dropped.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc8_q, skid_pc8_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc8_q, pc8_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic        load;
    logic [31:0] load_instr;
    logic [31:0] load_pc8;

    // NOTE: every signal driven here gets a default first, so no path through
    // the decision tree leaves one unassigned and no latch is inferred.
    always_comb begin
        redirect     = BranchTakenE | PCSrcW;
        target       = BranchTakenE ? ALUResultE : ResultW;
        pc_plus4     = pcf_q + 32'd4;
        pc_plus8     = pcf_q + 32'd8;

        // Depends only on registered state and non-memory inputs, so there is
        // no combinational path from imem_rvalid to imem_req.
        imem_req     = (state_q == S_REQ) && !reset && !PCWrPendingF && !redirect;

        state_d      = state_q;
        pcf_d        = pcf_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc8_d   = skid_pc8_q;
        load         = 1'b0;
        load_instr   = imem_rdata;
        load_pc8     = pc_plus8;

        if (redirect) begin
            pcf_d        = target;
            skid_valid_d = 1'b0;
            // A request still in flight must have its response swallowed;
            // a response arriving in this very cycle is simply ignored.
            if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_req) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (StallD) begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem_rdata;
                            skid_pc8_d   = pc_plus8;
                            pcf_d        = pc_plus4;
                            state_d      = S_FULL;
                        end else if (FlushD) begin
                            state_d = S_REQ;
                        end else begin
                            load    = 1'b1;
                            pcf_d   = pc_plus4;
                            state_d = S_REQ;
                        end
                    end
                end
                S_FULL: begin
                    if (!StallD) begin
                        load         = skid_valid_q;
                        load_instr   = skid_instr_q;
                        load_pc8     = skid_pc8_q;
                        skid_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        // IF/ID precedence: flush, then stall (hold), then load.
        instr_d = instr_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = BUBBLE;
            pc8_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!StallD && load) begin
            instr_d = load_instr;
            pc8_d   = load_pc8;
            valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pcf_q        <= RESET_PC;
            skid_valid_q <= 1'b0;
            instr_q      <= BUBBLE;
            pc8_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            skid_valid_q <= skid_valid_d;
            instr_q      <= instr_d;
            pc8_q        <= pc8_d;
            valid_q      <= valid_d;
        end
    end

    // NOTE: skid payload is not reset; it is only ever read while
    // skid_valid_q is set, so its power-up contents never escape.
    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc8_q   <= skid_pc8_d;
    end

    assign imem_addr = pcf_q;
    assign PCF       = pcf_q;
    assign InstrD    = instr_q;
    assign PCPlus8D  = pc8_q;
    assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A variable-latency memory answers the
// DUT's requests; a transaction-level reference model (pending request,
// stale flag, skid occupancy, IF/ID contents) predicts every output.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE   = 32'hE180_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        StallD, FlushD, PCWrPendingF, BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic [31:0] PCF, InstrD, PCPlus8D;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .BUBBLE(BUBBLE)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .StallD(StallD), .FlushD(FlushD), .PCWrPendingF(PCWrPendingF),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
    );

    int n_vec = 0;
    int n_err = 0;

    // memory environment
    int          lat = 1;          // 0 selects a random latency 1..4 per request
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;

    // reference model
    logic [31:0] m_pc, m_si, m_sp, m_instr, m_pc8;
    logic        m_out, m_stale, m_skid, m_valid;
    logic        exp_req, obs_req;
    logic [31:0] exp_addr, obs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic idle();
        StallD = 0; FlushD = 0; PCWrPendingF = 0;
        BranchTakenE = 0; PCSrcW = 0; ALUResultE = 0; ResultW = 0;
    endtask

    // Advance the reference model by one cycle using the current inputs.
    task automatic model_step();
        logic        redirect, ld;
        logic [31:0] tgt, ld_i, ld_p;
        redirect = BranchTakenE | PCSrcW;
        tgt      = BranchTakenE ? ALUResultE : ResultW;
        exp_req  = !reset && !m_out && !m_skid && !PCWrPendingF && !redirect;
        ld = 0; ld_i = 0; ld_p = 0;
        if (reset) begin
            m_pc = RESET_PC; m_out = 0; m_stale = 0; m_skid = 0;
            m_instr = BUBBLE; m_pc8 = 0; m_valid = 0;
        end else begin
            if (redirect) begin
                if (m_out && !imem_rvalid) m_stale = 1;
                else begin m_out = 0; m_stale = 0; end
                m_skid = 0;
                m_pc = tgt;
            end else if (m_out && imem_rvalid) begin
                if (!m_stale) begin
                    if (StallD) begin
                        m_skid = 1; m_si = imem_rdata; m_sp = m_pc + 8; m_pc = m_pc + 4;
                    end else if (!FlushD) begin
                        ld = 1; ld_i = imem_rdata; ld_p = m_pc + 8; m_pc = m_pc + 4;
                    end
                end
                m_out = 0; m_stale = 0;
            end else if (m_skid && !StallD) begin
                ld = 1; ld_i = m_si; ld_p = m_sp; m_skid = 0;
            end else if (exp_req) begin
                m_out = 1; m_stale = 0;
            end
            if (FlushD) begin
                m_instr = BUBBLE; m_pc8 = 0; m_valid = 0;
            end else if (!StallD && ld) begin
                m_instr = ld_i; m_pc8 = ld_p; m_valid = 1;
            end
        end
    endtask

    // One clock cycle: memory response at the negedge, sample request outputs,
    // step the model, accept the request, then return #1 after the posedge.
    task automatic tick();
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end
        end
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        exp_addr = m_pc;
        model_step();
        if (imem_req === 1'b1) begin
            mem_busy = 1'b1;
            mem_cnt  = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
            mem_addr = imem_addr;
        end
        if (reset) mem_busy = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        tick(); tick();
        n_vec++; if (PCF !== RESET_PC) begin n_err++; $display("FAIL reset_pcf: got %h want %h", PCF, RESET_PC); end
        n_vec++; if (InstrD !== BUBBLE) begin n_err++; $display("FAIL reset_instr: got %h want %h", InstrD, BUBBLE); end
        n_vec++; if (PCPlus8D !== 32'd0) begin n_err++; $display("FAIL reset_pc8: got %h want 0", PCPlus8D); end
        n_vec++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ValidD); end
        n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", obs_req); end
    endtask

    task automatic test_straight_line();
        logic [31:0] a;
        reset = 0; lat = 1; idle();
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            tick();
            n_vec++; if (obs_req !== 1'b1 || obs_addr !== a) begin n_err++; $display("FAIL straight_req%0d: got %b/%h want 1/%h", k, obs_req, obs_addr, a); end
            tick();
            n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL straight_gap%0d: got req %b want 0", k, obs_req); end
            n_vec++; if (InstrD !== mem_word(a) || ValidD !== 1'b1) begin n_err++; $display("FAIL straight_instr%0d: got %h/%b want %h/1", k, InstrD, ValidD, mem_word(a)); end
            n_vec++; if (PCPlus8D !== a + 32'd8) begin n_err++; $display("FAIL straight_pc8_%0d: got %h want %h", k, PCPlus8D, a + 32'd8); end
        end
    endtask

    task automatic test_decode_stall();
        idle();
        tick();  // request at 0xC
        StallD = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL stall_req%0d: got %b want 0", k, obs_req); end
            n_vec++; if (InstrD !== mem_word(32'h8) || PCPlus8D !== 32'h10) begin n_err++; $display("FAIL stall_hold%0d: got %h/%h want %h/00000010", k, InstrD, PCPlus8D, mem_word(32'h8)); end
            n_vec++; if (PCF !== 32'h10) begin n_err++; $display("FAIL stall_pcf%0d: got %h want 00000010", k, PCF); end
        end
        StallD = 0;
        tick();
        n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL stall_release_req: got %b want 0", obs_req); end
        n_vec++; if (InstrD !== mem_word(32'hC) || PCPlus8D !== 32'h14 || ValidD !== 1'b1) begin n_err++; $display("FAIL stall_skid: got %h/%h/%b want %h/00000014/1", InstrD, PCPlus8D, ValidD, mem_word(32'hC)); end
    endtask

    task automatic test_branch_drain();
        lat = 3; idle();
        tick();  // request at 0x10, three-cycle latency
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h10) begin n_err++; $display("FAIL drain_req: got %b/%h want 1/00000010", obs_req, obs_addr); end
        BranchTakenE = 1; ALUResultE = 32'h100; FlushD = 1;
        tick();
        idle();
        n_vec++; if (PCF !== 32'h100 || ValidD !== 1'b0) begin n_err++; $display("FAIL drain_redirect: got %h/%b want 00000100/0", PCF, ValidD); end
        tick(); tick();  // stale word returns in the second of these
        n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL drain_noreq: got %b want 0", obs_req); end
        n_vec++; if (InstrD !== BUBBLE || ValidD !== 1'b0) begin n_err++; $display("FAIL drain_stale: got %h/%b want %h/0", InstrD, ValidD, BUBBLE); end
        tick();
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin n_err++; $display("FAIL drain_newreq: got %b/%h want 1/00000100", obs_req, obs_addr); end
        tick(); tick(); tick();
        n_vec++; if (InstrD !== mem_word(32'h100) || PCPlus8D !== 32'h108) begin n_err++; $display("FAIL drain_target: got %h/%h want %h/00000108", InstrD, PCPlus8D, mem_word(32'h100)); end
    endtask

    task automatic test_simultaneous_redirect();
        lat = 1; idle();
        BranchTakenE = 1; ALUResultE = 32'h200; PCSrcW = 1; ResultW = 32'h300; FlushD = 1;
        tick();
        idle();
        n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL simul_req: got %b want 0", obs_req); end
        n_vec++; if (PCF !== 32'h200) begin n_err++; $display("FAIL simul_pcf: got %h want 00000200", PCF); end
        tick();
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin n_err++; $display("FAIL simul_next: got %b/%h want 1/00000200", obs_req, obs_addr); end
        tick();
        n_vec++; if (InstrD !== mem_word(32'h200)) begin n_err++; $display("FAIL simul_instr: got %h want %h", InstrD, mem_word(32'h200)); end
    endtask

    task automatic test_pc_write_pending();
        idle();
        PCWrPendingF = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL pcwr_block%0d: got %b want 0", k, obs_req); end
        end
        PCWrPendingF = 0; PCSrcW = 1; ResultW = 32'h40; FlushD = 1;
        tick();
        idle();
        tick();
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h40) begin n_err++; $display("FAIL pcwr_target: got %b/%h want 1/00000040", obs_req, obs_addr); end
        tick();
    endtask

    task automatic test_flush_stall_wrap();
        idle();
        FlushD = 1; StallD = 1;
        tick();
        idle();
        n_vec++; if (InstrD !== BUBBLE || ValidD !== 1'b0 || PCPlus8D !== 32'd0) begin n_err++; $display("FAIL flush_stall: got %h/%b/%h want %h/0/0", InstrD, ValidD, PCPlus8D, BUBBLE); end
        tick();  // completes the request issued during the flush cycle
        PCSrcW = 1; ResultW = 32'hFFFF_FFFC; FlushD = 1;
        tick();
        idle();
        tick();
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", obs_req, obs_addr); end
        tick();
        n_vec++; if (PCF !== 32'd0) begin n_err++; $display("FAIL wrap_pcf: got %h want 00000000", PCF); end
        n_vec++; if (PCPlus8D !== 32'h4 || InstrD !== mem_word(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_pc8: got %h/%h want 00000004/%h", PCPlus8D, InstrD, mem_word(32'hFFFF_FFFC)); end
    endtask

    task automatic drive_random();
        int r;
        idle();
        StallD       = ($urandom_range(0, 9) < 3);
        PCWrPendingF = ($urandom_range(0, 9) < 2);
        r = $urandom_range(0, 99);
        if (r < 5) begin
            BranchTakenE = 1; ALUResultE = $urandom & 32'hFFFF_FFFC;
        end
        if (r >= 3 && r < 8) begin
            PCSrcW = 1; ResultW = (r == 7) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        end
        FlushD = BranchTakenE | PCSrcW | (r >= 97);
    endtask

    task automatic test_random();
        reset = 1; idle();
        tick(); tick();
        reset = 0; lat = 0;
        for (int i = 0; i < 2000; i++) begin
            drive_random();
            tick();
            n_vec++; if (obs_req !== exp_req) begin n_err++; $display("FAIL rand_req c%0d: got %b want %b", i, obs_req, exp_req); end
            n_vec++; if (obs_addr !== exp_addr) begin n_err++; $display("FAIL rand_addr c%0d: got %h want %h", i, obs_addr, exp_addr); end
            n_vec++; if (PCF !== m_pc) begin n_err++; $display("FAIL rand_pcf c%0d: got %h want %h", i, PCF, m_pc); end
            n_vec++; if (InstrD !== m_instr) begin n_err++; $display("FAIL rand_instr c%0d: got %h want %h", i, InstrD, m_instr); end
            n_vec++; if (PCPlus8D !== m_pc8) begin n_err++; $display("FAIL rand_pc8 c%0d: got %h want %h", i, PCPlus8D, m_pc8); end
            n_vec++; if (ValidD !== m_valid) begin n_err++; $display("FAIL rand_valid c%0d: got %b want %b", i, ValidD, m_valid); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        imem_rvalid = 0; imem_rdata = 0;
        test_reset();
        test_straight_line();
        test_decode_stall();
        test_branch_drain();
        test_simultaneous_redirect();
        test_pc_write_pending();
        test_flush_stall_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
